// File: rtl/sentinel_key_tx.sv
// sentinel_key_tx: framed MSB-first key transmitter with ack/nack retry; define SENTINEL_TX_PARITY_EN to append an even-parity bit
module sentinel_key_tx #(
  parameter int KEY_W = 8,
  parameter int BIT_CYCLES = 4,
  parameter int MAX_TRIES = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             send,
  input  logic             ack_in,
  input  logic             nack_in,
  output logic             tx_frame,
  output logic             tx_data,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [1:0]       attempts
);
  localparam int CMAX = BIT_CYCLES > ACK_TIMEOUT ? BIT_CYCLES : ACK_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = KEY_W > 1 ? $clog2(KEY_W) : 1;
  localparam logic [1:0] MT = 2'(MAX_TRIES);
  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
`ifdef SENTINEL_TX_PARITY_EN
    PARITY,
`endif
    WAIT_ACK,
    DONE,
    FAIL
  } state_t;
  state_t state, state_n;
  logic [KEY_W-1:0] key;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic bit_end, wait_end, retry;
`ifdef SENTINEL_TX_PARITY_EN
  logic par;
`endif
  assign bit_end = cnt == CW'(BIT_CYCLES - 1);
  assign wait_end = cnt == CW'(ACK_TIMEOUT - 1);
  assign retry = nack_in | (~ack_in & wait_end);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign fail = state == FAIL;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      key <= '0;
      cnt <= '0;
      idx <= '0;
      attempts <= '0;
`ifdef SENTINEL_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= (state_n != state || (state == SHIFT && bit_end)) ? '0 : cnt + 1'b1;
      idx <= state == SHIFT ? idx - IW'(bit_end) : IW'(KEY_W - 1);
      if (state == IDLE && send) begin
        key <= key_in;
        attempts <= 2'd1;
`ifdef SENTINEL_TX_PARITY_EN
        par <= ^key_in;
`endif
      end
      if (state == WAIT_ACK && state_n == START) attempts <= attempts + 2'd1;
    end
  end
  always_comb begin
    state_n = state;
    tx_frame = 1'b0;
    tx_data = 1'b0;
    case (state)
      IDLE: state_n = send ? START : IDLE;
      START: begin
        tx_frame = 1'b1;
        tx_data = 1'b1;
        state_n = bit_end ? SHIFT : START;
      end
      SHIFT: begin
        tx_frame = 1'b1;
        tx_data = key[idx];
`ifdef SENTINEL_TX_PARITY_EN
        state_n = (bit_end && idx == '0) ? PARITY : SHIFT;
`else
        state_n = (bit_end && idx == '0) ? WAIT_ACK : SHIFT;
`endif
      end
`ifdef SENTINEL_TX_PARITY_EN
      PARITY: begin
        tx_frame = 1'b1;
        tx_data = par;
        state_n = bit_end ? WAIT_ACK : PARITY;
      end
`endif
      WAIT_ACK: state_n = retry ? (attempts < MT ? START : FAIL) : ack_in ? DONE : WAIT_ACK;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sentinel_key_tx.sv
// tb_sentinel_key_tx: randomized transactions checked cycle by cycle against an expected-trace model
module tb_sentinel_key_tx;
  localparam int KW = 8;
  localparam int BC = 4;
  localparam int MT = 3;
  localparam int AT = 16;
`ifdef SENTINEL_TX_PARITY_EN
  localparam int NB = KW + 2;
`else
  localparam int NB = KW + 1;
`endif
  typedef struct {
    logic [4:0] o;
    logic w;
    logic a;
    logic n;
  } cyc_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic send = 1'b0;
  logic ack_in = 1'b0;
  logic nack_in = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic tx_frame, tx_data, busy, done, fail;
  logic [1:0] attempts;
  int n_chk = 0;
  int n_pass = 0;
  int plan_t[3];
  int plan_d[3];
  cyc_t q[$];
  always #5 clk = ~clk;
  sentinel_key_tx #(.KEY_W(KW), .BIT_CYCLES(BC), .MAX_TRIES(MT), .ACK_TIMEOUT(AT)) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .send(send),
    .ack_in(ack_in),
    .nack_in(nack_in),
    .tx_frame(tx_frame),
    .tx_data(tx_data),
    .busy(busy),
    .done(done),
    .fail(fail),
    .attempts(attempts)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [4:0] outs();
    return {busy, tx_frame, tx_data, done, fail};
  endfunction
  function automatic cyc_t mk(input logic [4:0] o, input logic w, input logic a, input logic n);
    cyc_t c;
    c.o = o;
    c.w = w;
    c.a = a;
    c.n = n;
    return c;
  endfunction
  task automatic set_plan(input int t0, input int d0, input int t1, input int d1, input int t2, input int d2);
    plan_t[0] = t0;
    plan_d[0] = d0;
    plan_t[1] = t1;
    plan_d[1] = d1;
    plan_t[2] = t2;
    plan_d[2] = d2;
  endtask
  task automatic run_txn(input logic [KW-1:0] k);
    logic [NB-1:0] fb;
    logic ok;
    int tries;
`ifdef SENTINEL_TX_PARITY_EN
    fb = {1'b1, k, ^k};
`else
    fb = {1'b1, k};
`endif
    q.delete();
    ok = 1'b0;
    tries = 0;
    for (int a = 0; a < MT && !ok; a++) begin
      tries++;
      for (int b = NB - 1; b >= 0; b--)
        for (int i = 0; i < BC; i++) q.push_back(mk({2'b11, fb[b], 2'b00}, 1'b0, 1'b0, 1'b0));
      if (plan_t[a] == 3) begin
        for (int i = 0; i < AT; i++) q.push_back(mk(5'b10000, 1'b1, 1'b0, 1'b0));
      end else begin
        for (int i = 0; i < plan_d[a]; i++) q.push_back(mk(5'b10000, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(5'b10000, 1'b1, plan_t[a] != 1, plan_t[a] != 0));
        ok = plan_t[a] == 0;
      end
    end
    q.push_back(mk(ok ? 5'b10010 : 5'b10001, 1'b0, 1'b0, 1'b0));
    send = 1'b1;
    key_in = k;
    foreach (q[i]) begin
      @(negedge clk);
      chk("out", 32'(outs()), 32'(q[i].o));
      send = 1'($urandom);
      key_in = KW'($urandom);
      ack_in = q[i].w ? q[i].a : 1'($urandom);
      nack_in = q[i].w ? q[i].n : 1'($urandom);
    end
    @(negedge clk);
    send = 1'b0;
    ack_in = 1'b0;
    nack_in = 1'b0;
    chk("idle", 32'(outs()), 32'd0);
    chk("attempts", 32'(attempts), 32'(tries));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(outs()), 32'd0);
    chk("rst_att", 32'(attempts), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    set_plan(0, 3, 0, 0, 0, 0);
    run_txn(8'hB6);
    set_plan(1, 2, 0, 5, 0, 0);
    run_txn(8'hB6);
    set_plan(3, 0, 3, 0, 3, 0);
    run_txn(8'h3C);
    set_plan(2, 4, 0, 1, 0, 0);
    run_txn(8'hA5);
    set_plan(0, AT - 1, 0, 0, 0, 0);
    run_txn(8'h01);
    set_plan(1, AT - 1, 2, 0, 0, 0);
    run_txn(8'h80);
    send = 1'b1;
    key_in = 8'hFF;
    repeat (14) begin
      @(negedge clk);
      send = 1'($urandom);
      key_in = 8'h00;
    end
    chk("pre_rst", 32'(outs()), 32'h1C);
    rst = 1'b1;
    send = 1'b1;
    @(negedge clk);
    chk("abort_out", 32'(outs()), 32'd0);
    chk("abort_att", 32'(attempts), 32'd0);
    rst = 1'b0;
    send = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst", 32'(outs()), 32'd0);
    end
    set_plan(0, 1, 0, 0, 0, 0);
    run_txn(8'h5A);
    repeat (40) begin
      for (int a = 0; a < 3; a++) begin
        plan_t[a] = $urandom_range(0, 3);
        plan_d[a] = $urandom_range(0, AT - 1);
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap", 32'(outs()), 32'd0);
      end
      run_txn(KW'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
